memwb_stage_reg: RTL and testbench

- MEM/WB pipeline register of the pipelined RISC-V core; sits directly upstream of the five-input writeback result mux.
- Captures the five result candidates, the 3-bit result-source select, and the destination register and write-enable info from the MEM stage.
- Sign/zero-extends load data before capture.
- Supports stall (hold) and flush (bubble insertion), and sanitises illegal select codes so the mux never sees select values 5-7.

---
 rtl/memwb_stage_reg.sv | 145 ++++++++++++++
 tb/tb_memwb_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage_reg.sv
// memwb_stage_reg: MEM/WB pipeline register feeding the five-input writeback
// result mux. Extends load data before capture, supports stall/flush and
// forces illegal result-source selects (5-7) to 0 so the mux never sees them.
// Optional feature: define MEMWB_RETIRE_COUNT_EN to build the retired-
// instruction counter on RetireCountW; otherwise that output is tied to 0.
module memwb_stage_reg #(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallW,
    input  logic                FlushW,
    input  logic                ValidM,
    input  logic                RegWriteM,
    input  logic [4:0]          RdM,
    input  logic [2:0]          ResultSrcM,
    input  logic [2:0]          LoadTypeM,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     ReadDataM,
    input  logic [XLEN-1:0]     PCPlus4M,
    input  logic [XLEN-1:0]     ImmExtM,
    input  logic [XLEN-1:0]     PCTargetM,
    output logic [XLEN-1:0]     ALUResultW,
    output logic [XLEN-1:0]     ReadDataW,
    output logic [XLEN-1:0]     PCPlus4W,
    output logic [XLEN-1:0]     ImmExtW,
    output logic [XLEN-1:0]     PCTargetW,
    output logic [2:0]          ResultSrcW,
    output logic [4:0]          RdW,
    output logic                RegWriteW,
    output logic                ValidW,
    output logic                IllegalSrcW,
    output logic [RETIRE_W-1:0] RetireCountW
);

    localparam logic [2:0] SRC_MAX = 3'd4;

    // Load funct3 encodings that need extension; everything else passes the raw word
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ld_ext;
    logic            w_legal;
    logic            w_load;

    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_tgt;
    logic [2:0]      r_src;
    logic [4:0]      r_rd;
    logic            r_rw;
    logic            r_vld;
    logic            r_ill;

    assign w_off   = ALUResultM[1:0];
    assign w_legal = (ResultSrcM <= SRC_MAX);
    // An edge "loads" only when nothing of higher priority claims it
    assign w_load  = !reset && !FlushW && !StallW;

    // Pick the addressed byte/halfword and extend per load type
    always_comb begin
        w_byte = ReadDataM[7:0];
        case (w_off)
            2'd0: w_byte = ReadDataM[7:0];
            2'd1: w_byte = ReadDataM[15:8];
            2'd2: w_byte = ReadDataM[23:16];
            2'd3: w_byte = ReadDataM[31:24];
            default: w_byte = ReadDataM[7:0];
        endcase
        // off[0] is ignored for halfwords; misalignment is not this stage's problem
        w_half = w_off[1] ? ReadDataM[31:16] : ReadDataM[15:0];
        case (LoadTypeM)
            LT_LB:   w_ld_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            LT_LBU:  w_ld_ext = {{(XLEN-8){1'b0}}, w_byte};
            LT_LH:   w_ld_ext = {{(XLEN-16){w_half[15]}}, w_half};
            LT_LHU:  w_ld_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld_ext = ReadDataM;
        endcase
    end

    // Stage register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset || FlushW) begin
            r_alu   <= '0;
            r_rdata <= '0;
            r_pc4   <= '0;
            r_imm   <= '0;
            r_tgt   <= '0;
            r_src   <= 3'd0;
            r_rd    <= 5'd0;
            r_rw    <= 1'b0;
            r_vld   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (!StallW) begin
            r_alu   <= ALUResultM;
            r_rdata <= w_ld_ext;
            r_pc4   <= PCPlus4M;
            r_imm   <= ImmExtM;
            r_tgt   <= PCTargetM;
            // Illegal selects collapse to the ALU path; data is still captured
            r_src   <= w_legal ? ResultSrcM : 3'd0;
            r_rd    <= RdM;
            r_rw    <= RegWriteM & ValidM & w_legal;
            r_vld   <= ValidM;
            r_ill   <= ValidM & !w_legal;
        end
    end

`ifdef MEMWB_RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] r_retire;

    // Count valid, legal instructions entering W; flush and stall hold, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire <= '0;
        end else if (w_load && ValidM && w_legal) begin
            r_retire <= r_retire + 1'b1;
        end
    end

    assign RetireCountW = r_retire;
`else
    assign RetireCountW = '0;
`endif

    assign ALUResultW  = r_alu;
    assign ReadDataW   = r_rdata;
    assign PCPlus4W    = r_pc4;
    assign ImmExtW     = r_imm;
    assign PCTargetW   = r_tgt;
    assign ResultSrcW  = r_src;
    assign RdW         = r_rd;
    assign RegWriteW   = r_rw;
    assign ValidW      = r_vld;
    assign IllegalSrcW = r_ill;

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Bench for memwb_stage_reg: hand-written vector table with fixed expectations,
// a retire-counter sequence, then randomized traffic against a reference model.
module tb_memwb_stage_reg;

    typedef struct packed {
        logic        rst, stall, flush, valid, rw;
        logic [4:0]  rd;
        logic [2:0]  src, lt;
        logic [31:0] alu, rdata, pc4, imm, tgt;
    } in_t;

    typedef struct packed {
        logic [31:0] alu, rdata, pc4, imm, tgt;
        logic [2:0]  src;
        logic [4:0]  rd;
        logic        rw, vld, ill;
        logic [63:0] cnt;
    } st_t;

    typedef struct {
        in_t         in;
        logic [31:0] e_rdata, e_tgt;
        logic [2:0]  e_src;
        logic        e_rw, e_ill, e_vld;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, StallW, FlushW, ValidM, RegWriteM;
    logic [4:0]  RdM;
    logic [2:0]  ResultSrcM, LoadTypeM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM, PCTargetM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW, PCTargetW;
    logic [2:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic        RegWriteW, ValidW, IllegalSrcW;
    logic [63:0] RetireCountW;

    int n_tests = 0;
    int n_fail  = 0;
    st_t model;
    vec_t tbl[$];

    always #5 clk = ~clk;

    memwb_stage_reg #(.XLEN(32), .RETIRE_W(64)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM),
        .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .ImmExtM(ImmExtM), .PCTargetM(PCTargetM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .ImmExtW(ImmExtW), .PCTargetW(PCTargetW), .ResultSrcW(ResultSrcW),
        .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW),
        .IllegalSrcW(IllegalSrcW), .RetireCountW(RetireCountW)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Load extension from the ISA rules using shifts and arithmetic
    function automatic logic [31:0] ext_ref(input logic [2:0] lt, input logic [31:0] w,
                                            input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (lt)
            3'd0: return (b > 127) ? b + 32'hFFFF_FF00 : b;
            3'd4: return b;
            3'd1: return (h > 32767) ? h + 32'hFFFF_0000 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic in_t mk(input logic rst, stall, flush, valid, rw,
                               input logic [4:0] rd, input logic [2:0] src, lt,
                               input logic [31:0] alu, rdata, pc4, imm, tgt);
        in_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.valid = valid; v.rw = rw;
        v.rd = rd; v.src = src; v.lt = lt; v.alu = alu; v.rdata = rdata;
        v.pc4 = pc4; v.imm = imm; v.tgt = tgt;
        return v;
    endfunction

    function automatic vec_t mv(input in_t in, input logic [31:0] er, et,
                                input logic [2:0] es, input logic erw, eill, evld);
        vec_t v;
        v.in = in; v.e_rdata = er; v.e_tgt = et; v.e_src = es;
        v.e_rw = erw; v.e_ill = eill; v.e_vld = evld;
        return v;
    endfunction

    // Drive one cycle, advance the model, compare every output against it
    task automatic apply(input in_t v);
        logic legal;
        reset = v.rst; StallW = v.stall; FlushW = v.flush; ValidM = v.valid;
        RegWriteM = v.rw; RdM = v.rd; ResultSrcM = v.src; LoadTypeM = v.lt;
        ALUResultM = v.alu; ReadDataM = v.rdata; PCPlus4M = v.pc4;
        ImmExtM = v.imm; PCTargetM = v.tgt;
        @(posedge clk);
        #1;
        legal = (v.src < 5);
        if (v.rst) begin
            model = '0;
        end else if (v.flush) begin
            model = '{cnt: model.cnt, default: '0};
        end else if (!v.stall) begin
            model.alu = v.alu; model.pc4 = v.pc4; model.imm = v.imm; model.tgt = v.tgt;
            model.rdata = ext_ref(v.lt, v.rdata, v.alu[1:0]);
            model.src = legal ? v.src : 3'd0;
            model.rd  = v.rd;
            model.rw  = v.rw && v.valid && legal;
            model.vld = v.valid;
            model.ill = v.valid && !legal;
`ifdef MEMWB_RETIRE_COUNT_EN
            if (v.valid && legal) model.cnt = model.cnt + 1;
`endif
        end
        chk("ALUResultW", ALUResultW, model.alu);
        chk("ReadDataW",  ReadDataW,  model.rdata);
        chk("PCPlus4W",   PCPlus4W,   model.pc4);
        chk("ImmExtW",    ImmExtW,    model.imm);
        chk("PCTargetW",  PCTargetW,  model.tgt);
        chk("ResultSrcW", ResultSrcW, model.src);
        chk("RdW",        RdW,        model.rd);
        chk("RegWriteW",  RegWriteW,  model.rw);
        chk("ValidW",     ValidW,     model.vld);
        chk("IllegalSrcW", IllegalSrcW, model.ill);
        chk("RetireCountW", RetireCountW, model.cnt);
    endtask

    initial begin
        logic [31:0] ld;
        in_t r;
        model = '0;
        ld = 32'h80FF_7F01;
        // rst stall flush valid rw rd src lt alu rdata pc4 imm tgt
        tbl.push_back(mv(mk(1,1,1,1,1,5'd31,3'd7,3'd0,'1,'1,'1,'1,'1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(mv(mk(1,1,1,1,1,5'd31,3'd7,3'd0,'1,'1,'1,'1,'1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd5,3'd4,3'd2,1,2,4,8,16), 2, 16, 4, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mv(mk(0,1,0,1,0,5'd9,3'd1,3'd2,7,7,7,7,32), 2, 16, 4, 1, 0, 1));
        tbl.push_back(mv(mk(0,1,1,1,1,5'd9,3'd1,3'd2,7,7,7,7,32), 0, 0, 0, 0, 0, 0));
        for (int s = 5; s < 8; s++)
            tbl.push_back(mv(mk(0,0,0,1,1,5'd3,3'(s),3'd2,0,32'h1234_5678,0,0,64),
                             32'h1234_5678, 64, 0, 0, 1, 1));
        for (int s = 5; s < 8; s++)
            tbl.push_back(mv(mk(0,0,0,0,1,5'd3,3'(s),3'd2,0,32'h1234_5678,0,0,64),
                             32'h1234_5678, 64, 0, 0, 0, 0));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd1,3'd1,3'd0,1,ld,0,0,0), 32'h0000_007F, 0, 1, 1, 0, 1));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd1,3'd1,3'd0,3,ld,0,0,0), 32'hFFFF_FF80, 0, 1, 1, 0, 1));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd1,3'd1,3'd4,2,ld,0,0,0), 32'h0000_00FF, 0, 1, 1, 0, 1));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd1,3'd1,3'd1,2,ld,0,0,0), 32'hFFFF_80FF, 0, 1, 1, 0, 1));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd1,3'd1,3'd5,3,ld,0,0,0), 32'h0000_80FF, 0, 1, 1, 0, 1));
        tbl.push_back(mv(mk(0,0,0,1,1,5'd0,3'd1,3'd2,0,ld,0,0,0), 32'h80FF_7F01, 0, 1, 1, 0, 1));

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            chk($sformatf("vec%0d ReadDataW", i),   ReadDataW,   tbl[i].e_rdata);
            chk($sformatf("vec%0d PCTargetW", i),   PCTargetW,   tbl[i].e_tgt);
            chk($sformatf("vec%0d ResultSrcW", i),  ResultSrcW,  tbl[i].e_src);
            chk($sformatf("vec%0d RegWriteW", i),   RegWriteW,   tbl[i].e_rw);
            chk($sformatf("vec%0d IllegalSrcW", i), IllegalSrcW, tbl[i].e_ill);
            chk($sformatf("vec%0d ValidW", i),      ValidW,      tbl[i].e_vld);
        end

        // Retire counter: 10 legal loads, 2 stalls, 1 flush, 1 illegal
        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 10; i++)
            apply(mk(0,0,0,1,1,5'(i+1),3'(i % 5),3'd2,i,i,i,i,i));
        apply(mk(0,1,0,1,1,5'd2,3'd0,3'd2,9,9,9,9,9));
        apply(mk(0,1,0,1,1,5'd2,3'd0,3'd2,9,9,9,9,9));
        apply(mk(0,0,1,1,1,5'd2,3'd0,3'd2,9,9,9,9,9));
        apply(mk(0,0,0,1,1,5'd2,3'd6,3'd2,9,9,9,9,9));
`ifdef MEMWB_RETIRE_COUNT_EN
        chk("retire count after sequence", RetireCountW, 64'd10);
`else
        chk("retire count tied off", RetireCountW, 64'd0);
`endif
        // Reset during stall+flush wins, next cycle loads normally
        apply(mk(1,1,1,1,1,5'd4,3'd2,3'd2,5,5,5,5,5));
        chk("reset over stall/flush ValidW", ValidW, 1'b0);
        apply(mk(0,0,0,1,1,5'd4,3'd2,3'd2,5,5,5,5,5));
        chk("load after reset RdW", RdW, 5'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
                   5'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom,
                   $urandom, $urandom, $urandom);
            apply(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
